// File: rtl/acq_trigger_sequencer.sv
// -----------------------------------------------------------------------------
// acq_trigger_sequencer
//
// Sequences one ADC acquisition in the clklvds domain. A rising edge on arm
// starts it; the trigger channel is then qualified against two signed
// thresholds (rising, falling, or rising with an auto-trigger timeout), and a
// programmed number of samples is written into the LVDS sample FIFO. Writes
// are held off while the FIFO is nearly full.
//
// Ports
//   clklvds      in   1   sample clock
//   rstn         in   1   asynchronous active-low reset
//   arm          in   1   level; rising edge starts an acquisition
//   abort        in   1   level; forces return to IDLE
//   trig_type    in   2   0 none, 1 rising, 2 falling, 3 rising + auto timeout
//   lowerthresh  in   12  signed lower threshold
//   upperthresh  in   12  signed upper threshold
//   length       in   16  samples to capture after trigger
//   samplevalue  in   12  signed trigger-channel sample, valid every cycle
//   fifo_wrused  in   11  FIFO write-side fill level
//   fifo_wr      out  1   FIFO write strobe (registered)
//   busy         out  1   high in any state except IDLE
//   done         out  1   one-cycle pulse at end of capture
//   auto_trig    out  1   sticky: last acquisition triggered by timeout
//   stalled      out  1   sticky: capture stalled on FIFO level
//   sample_cnt   out  16  samples written in the current/last acquisition
// -----------------------------------------------------------------------------
module acq_trigger_sequencer #(
    parameter int unsigned FIFO_LIMIT  = 1020,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic               clklvds,
    input  logic               rstn,
    input  logic               arm,
    input  logic               abort,
    input  logic [1:0]         trig_type,
    input  logic signed [11:0] lowerthresh,
    input  logic signed [11:0] upperthresh,
    input  logic [15:0]        length,
    input  logic signed [11:0] samplevalue,
    input  logic [10:0]        fifo_wrused,
    output logic               fifo_wr,
    output logic               busy,
    output logic               done,
    output logic               auto_trig,
    output logic               stalled,
    output logic [15:0]        sample_cnt
);

    localparam logic [10:0] LIMIT        = 11'(FIFO_LIMIT);
    // Transition is taken in the cycle the counter holds TIMEOUT_CYC-1, so
    // CAPTURE begins exactly TIMEOUT_CYC cycles after entering WAIT_A.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_A,
        WAIT_B,
        CAPTURE,
        DONE
    } state_t;

    state_t             state;
    logic               arm_q;
    logic [1:0]         type_l;
    logic signed [11:0] lower_l;
    logic signed [11:0] upper_l;
    logic [15:0]        length_l;
    logic [15:0]        tcnt;

    logic start;
    logic a_hit;
    logic b_hit;
    logic timeout_hit;

    assign start = arm & ~arm_q;

    // Falling trigger swaps the order of the two threshold crossings.
    always_comb begin
        a_hit       = 1'b0;
        b_hit       = 1'b0;
        timeout_hit = 1'b0;
        if (type_l == 2'd2) begin
            a_hit = samplevalue > upper_l;
            b_hit = samplevalue < lower_l;
        end else begin
            a_hit = samplevalue < lower_l;
            b_hit = samplevalue > upper_l;
        end
        timeout_hit = (type_l == 2'd3) && (tcnt == TIMEOUT_LAST);
    end

    always_ff @(posedge clklvds or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            arm_q      <= 1'b0;
            type_l     <= 2'd0;
            lower_l    <= '0;
            upper_l    <= '0;
            length_l   <= '0;
            tcnt       <= '0;
            fifo_wr    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            auto_trig  <= 1'b0;
            stalled    <= 1'b0;
            sample_cnt <= '0;
        end else begin
            arm_q <= arm;
            if (abort) begin
                // Counters and sticky flags are kept for post-mortem readout.
                state   <= IDLE;
                fifo_wr <= 1'b0;
                done    <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        fifo_wr <= 1'b0;
                        done    <= 1'b0;
                        if (start) begin
                            sample_cnt <= '0;
                            auto_trig  <= 1'b0;
                            stalled    <= 1'b0;
                            type_l     <= trig_type;
                            lower_l    <= lowerthresh;
                            upper_l    <= upperthresh;
                            length_l   <= length;
                            tcnt       <= '0;
                            busy       <= 1'b1;
                            state      <= (trig_type == 2'd0) ? CAPTURE : WAIT_A;
                        end
                    end
                    WAIT_A: begin
                        tcnt <= tcnt + 16'd1;
                        if (timeout_hit) begin
                            auto_trig <= 1'b1;
                            state     <= CAPTURE;
                        end else if (a_hit) begin
                            state <= WAIT_B;
                        end
                    end
                    WAIT_B: begin
                        tcnt <= tcnt + 16'd1;
                        // A real trigger takes precedence over a coincident timeout.
                        if (b_hit) begin
                            state <= CAPTURE;
                        end else if (timeout_hit) begin
                            auto_trig <= 1'b1;
                            state     <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (sample_cnt == length_l) begin
                            fifo_wr <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else if (fifo_wrused < LIMIT) begin
                            fifo_wr    <= 1'b1;
                            sample_cnt <= sample_cnt + 16'd1;
                        end else begin
                            fifo_wr <= 1'b0;
                            stalled <= 1'b1;
                        end
                    end
                    DONE: begin
                        fifo_wr <= 1'b0;
                        done    <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                    default: begin
                        fifo_wr <= 1'b0;
                        done    <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acq_trigger_sequencer.sv
// -----------------------------------------------------------------------------
// tb_acq_trigger_sequencer
//
// Self-checking bench for acq_trigger_sequencer. Stimulus pushes the expected
// fifo_wr / done events (cycle number and sample_cnt) into a queue; a monitor
// on the falling edge pops and compares whenever the DUT strobes an output.
// -----------------------------------------------------------------------------
module tb_acq_trigger_sequencer;

    logic               clklvds = 1'b0;
    logic               rstn;
    logic               arm;
    logic               abort;
    logic [1:0]         trig_type;
    logic signed [11:0] lowerthresh;
    logic signed [11:0] upperthresh;
    logic [15:0]        length;
    logic signed [11:0] samplevalue;
    logic [10:0]        fifo_wrused;
    logic               fifo_wr;
    logic               busy;
    logic               done;
    logic               auto_trig;
    logic               stalled;
    logic [15:0]        sample_cnt;

    acq_trigger_sequencer #(
        .FIFO_LIMIT (1020),
        .TIMEOUT_CYC(100)
    ) dut (
        .clklvds    (clklvds),
        .rstn       (rstn),
        .arm        (arm),
        .abort      (abort),
        .trig_type  (trig_type),
        .lowerthresh(lowerthresh),
        .upperthresh(upperthresh),
        .length     (length),
        .samplevalue(samplevalue),
        .fifo_wrused(fifo_wrused),
        .fifo_wr    (fifo_wr),
        .busy       (busy),
        .done       (done),
        .auto_trig  (auto_trig),
        .stalled    (stalled),
        .sample_cnt (sample_cnt)
    );

    always #5 clklvds = ~clklvds;

    int cyc = 0;
    always @(posedge clklvds) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int cyc;
        int cnt;
    } ev_t;

    ev_t expq[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input int cnt);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.cnt  = cnt;
        expq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clklvds);
        #1;
    endtask

    task automatic match_event(input int kind);
        ev_t e;
        string nm;
        nm = (kind == 0) ? "fifo_wr" : "done";
        checks++;
        if (expq.size() > 0 && expq[0].cyc == cyc && expq[0].kind == kind) begin
            e = expq.pop_front();
            if (sample_cnt != 16'(e.cnt)) begin
                failures++;
                $display("[TB] FAIL %s_cnt: actual=%0d required=%0d (cycle %0d)",
                         nm, sample_cnt, e.cnt, cyc);
            end
        end else begin
            failures++;
            $display("[TB] FAIL unexpected_%s: actual=1 required=0 (cycle %0d)", nm, cyc);
        end
    endtask

    // Monitor: retire expected events that were never seen, then match strobes.
    always @(negedge clklvds) begin
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
            checks++;
            failures++;
            $display("[TB] FAIL missed_event: kind=%0d required_cycle=%0d actual=absent (cycle %0d)",
                     expq[0].kind, expq[0].cyc, cyc);
            void'(expq.pop_front());
        end
        if (fifo_wr === 1'b1) match_event(0);
        if (done === 1'b1) match_event(1);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus();
        int c0;

        // Reset state
        rstn = 1'b0; arm = 1'b0; abort = 1'b0; trig_type = 2'd0;
        lowerthresh = '0; upperthresh = '0; length = '0;
        samplevalue = '0; fifo_wrused = '0;
        step(3);
        check_output("rst_fifo_wr", fifo_wr, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_flags", {auto_trig, stalled}, 0);
        check_output("rst_sample_cnt", sample_cnt, 0);
        rstn = 1'b1;
        step(2);

        // T1: type 0, length 8; config changed mid-capture must be ignored
        trig_type = 2'd0; length = 16'd8; fifo_wrused = 11'd0;
        c0 = cyc;
        for (int k = 1; k <= 8; k++) push_ev(0, c0 + 1 + k, k);
        push_ev(1, c0 + 10, 8);
        arm = 1'b1; step(1); arm = 1'b0;
        step(2);
        length = 16'd3; trig_type = 2'd2;
        step(10);
        check_output("t1_busy", busy, 0);
        check_output("t1_sample_cnt", sample_cnt, 8);
        check_output("t1_flags", {auto_trig, stalled}, 0);
        check_output("t1_drained", expq.size(), 0);

        // T2: rising trigger, thresholds -10/+10, equal values do not qualify
        trig_type = 2'd1; lowerthresh = -12'sd10; upperthresh = 12'sd10;
        length = 16'd4; samplevalue = 12'sd0;
        c0 = cyc;
        for (int k = 1; k <= 4; k++) push_ev(0, c0 + 7 + k, k);
        push_ev(1, c0 + 12, 4);
        arm = 1'b1; step(1); arm = 1'b0; samplevalue = 12'sd0;
        step(1); samplevalue = -12'sd10;
        step(1); samplevalue = -12'sd11;
        step(1); samplevalue = 12'sd10;
        step(1); samplevalue = 12'sd5;
        check_output("t2_busy_waiting", busy, 1);
        step(1); samplevalue = 12'sd11;
        step(1); samplevalue = 12'sd0;
        step(8);
        check_output("t2_sample_cnt", sample_cnt, 4);
        check_output("t2_auto_trig", auto_trig, 0);
        check_output("t2_drained", expq.size(), 0);

        // T2b: falling trigger
        trig_type = 2'd2; length = 16'd2;
        c0 = cyc;
        push_ev(0, c0 + 6, 1);
        push_ev(0, c0 + 7, 2);
        push_ev(1, c0 + 8, 2);
        arm = 1'b1; step(1); arm = 1'b0; samplevalue = 12'sd10;
        step(1); samplevalue = 12'sd11;
        step(1); samplevalue = -12'sd10;
        step(1); samplevalue = -12'sd11;
        step(1); samplevalue = 12'sd0;
        step(6);
        check_output("t2b_sample_cnt", sample_cnt, 2);
        check_output("t2b_drained", expq.size(), 0);

        // T3: auto-trigger timeout (100 cycles) on a flat input
        trig_type = 2'd3; length = 16'd3; samplevalue = 12'sd0;
        c0 = cyc;
        for (int k = 1; k <= 3; k++) push_ev(0, c0 + 101 + k, k);
        push_ev(1, c0 + 105, 3);
        arm = 1'b1; step(1); arm = 1'b0;
        step(99);
        check_output("t3_busy_waiting", busy, 1);
        check_output("t3_auto_before", auto_trig, 0);
        step(8);
        check_output("t3_auto_trig", auto_trig, 1);
        check_output("t3_sample_cnt", sample_cnt, 3);
        check_output("t3_drained", expq.size(), 0);

        // T4: FIFO stall; 1019 still writes, 1020 stalls for 7 decisions
        trig_type = 2'd0; length = 16'd16; fifo_wrused = 11'd1019;
        c0 = cyc;
        push_ev(0, c0 + 2, 1);
        push_ev(0, c0 + 3, 2);
        for (int k = 3; k <= 16; k++) push_ev(0, c0 + 8 + k, k);
        push_ev(1, c0 + 25, 16);
        arm = 1'b1; step(1); arm = 1'b0;
        step(2); fifo_wrused = 11'd1020;
        step(2);
        check_output("t4_stalled_mid", stalled, 1);
        check_output("t4_auto_cleared", auto_trig, 0);
        step(5); fifo_wrused = 11'd0;
        step(18);
        check_output("t4_sample_cnt", sample_cnt, 16);
        check_output("t4_stalled", stalled, 1);
        check_output("t4_drained", expq.size(), 0);

        // T5: abort on the 5th write, arm edge during abort ignored, then re-arm
        length = 16'd20;
        c0 = cyc;
        for (int k = 1; k <= 5; k++) push_ev(0, c0 + 1 + k, k);
        arm = 1'b1; step(1); arm = 1'b0;
        step(5); abort = 1'b1;
        step(1);
        check_output("t5_fifo_wr_abort", fifo_wr, 0);
        check_output("t5_busy_abort", busy, 0);
        arm = 1'b1;
        step(1); abort = 1'b0; arm = 1'b0;
        step(3);
        check_output("t5_no_restart", busy, 0);
        check_output("t5_sample_cnt", sample_cnt, 5);
        check_output("t5_stalled_cleared", stalled, 0);
        length = 16'd2;
        c0 = cyc;
        push_ev(0, c0 + 2, 1);
        push_ev(0, c0 + 3, 2);
        push_ev(1, c0 + 4, 2);
        arm = 1'b1; step(1); arm = 1'b0;
        step(6);
        check_output("t5_rearm_cnt", sample_cnt, 2);
        check_output("t5_drained", expq.size(), 0);

        // T6: length 0 with arm held high
        length = 16'd0;
        c0 = cyc;
        push_ev(1, c0 + 2, 0);
        arm = 1'b1; step(8);
        check_output("t6_busy", busy, 0);
        check_output("t6_sample_cnt", sample_cnt, 0);
        arm = 1'b0; step(1);
        check_output("t6_drained", expq.size(), 0);

        // T7: asynchronous reset mid-capture
        length = 16'd10;
        c0 = cyc;
        push_ev(0, c0 + 2, 1);
        push_ev(0, c0 + 3, 2);
        arm = 1'b1; step(1); arm = 1'b0;
        step(3);
        #1 rstn = 1'b0;
        #1;
        check_output("t7_fifo_wr_async", fifo_wr, 0);
        check_output("t7_busy_async", busy, 0);
        check_output("t7_sample_cnt", sample_cnt, 0);
        step(2); rstn = 1'b1;
        step(2);
        check_output("t7_drained", expq.size(), 0);
    endtask

    initial begin
        apply_stimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
